// File: rtl/fp8_seq_multiplier_pkg.sv
// Shared definitions for the 8-bit minifloat FPU: format widths, special
// encodings, operation codes and the multiplier FSM state encoding.
package fp8_seq_multiplier_pkg;

    localparam int FP_W       = 8;
    localparam int FP_EXP_W   = 4;
    localparam int FP_MANT_W  = 3;
    localparam int FP_BIAS    = 7;
    localparam int FP_E_W     = 6;

    localparam logic [FP_W-1:0] NAN       = 8'h7F;
    localparam logic [FP_W-1:0] PLUS_INF  = 8'h78;
    localparam logic [FP_W-1:0] MINUS_INF = 8'hF8;

    typedef enum logic [1:0] {
        OP_ADDITION       = 2'd0,
        OP_SUBTRACTION    = 2'd1,
        OP_MULTIPLICATION = 2'd2
    } fp_op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        MULT   = 3'd2,
        NORM   = 3'd3,
        PACK   = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/fp8_seq_multiplier_if.sv
// Operand/result handshake bundle between the FPU parent and the multiplier.
interface fp8_seq_multiplier_if;
    import fp8_seq_multiplier_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [FP_W-1:0] op_a;
    logic [FP_W-1:0] op_b;
    logic            op_is_exception;
    logic            out_valid;
    logic            out_ready;
    logic [FP_W-1:0] result;
    logic            flag_invalid;
    logic            flag_overflow;
    logic            flag_underflow;

    modport master (
        output in_valid, op_a, op_b, op_is_exception, out_ready,
        input  in_ready, out_valid, result, flag_invalid, flag_overflow, flag_underflow
    );

    modport slave (
        input  in_valid, op_a, op_b, op_is_exception, out_ready,
        output in_ready, out_valid, result, flag_invalid, flag_overflow, flag_underflow
    );

endinterface

// File: rtl/fp8_round_pack.sv
// Combinational round-to-nearest-even and pack stage; saturates to infinity
// on exponent overflow and flushes to signed zero on underflow.
module fp8_round_pack
    import fp8_seq_multiplier_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W,
    parameter int E_W    = FP_E_W
) (
    input  logic                     sign,
    input  logic signed [E_W-1:0]    exp_in,
    input  logic [MANT_W-1:0]        keep,
    input  logic                     guard,
    input  logic                     sticky,
    output logic [EXP_W+MANT_W:0]    result,
    output logic                     overflow,
    output logic                     underflow
);

    localparam logic signed [E_W-1:0] EXP_MAX  = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] EXP_ZERO = '0;

    logic                  round_up;
    logic [MANT_W:0]       rounded;
    logic signed [E_W-1:0] exp_adj;

    // A carry out of the rounded mantissa leaves its low bits at zero, so only
    // the exponent needs the extra increment.
    always_comb begin
        round_up  = guard & (sticky | keep[0]);
        rounded   = {1'b0, keep} + {{MANT_W{1'b0}}, round_up};
        exp_adj   = exp_in + $signed({{(E_W-1){1'b0}}, rounded[MANT_W]});
        overflow  = 1'b0;
        underflow = 1'b0;
        result    = {sign, exp_adj[EXP_W-1:0], rounded[MANT_W-1:0]};
        if (exp_adj >= EXP_MAX) begin
            overflow = 1'b1;
            result   = sign ? MINUS_INF : PLUS_INF;
        end else if (exp_adj <= EXP_ZERO) begin
            underflow = 1'b1;
            result    = {sign, {(EXP_W+MANT_W){1'b0}}};
        end
    end

endmodule

// File: rtl/fp8_seq_multiplier.sv
// Multi-cycle minifloat multiplier: shift-add significand product, then
// normalise, round and pack, with valid/ready handshakes on both sides.
module fp8_seq_multiplier
    import fp8_seq_multiplier_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W,
    parameter int BIAS   = FP_BIAS
) (
    input  logic                 clk,
    input  logic                 rst,
    fp8_seq_multiplier_if.slave  bus
);

    localparam int FP_WIDTH = EXP_W + MANT_W + 1;
    localparam int SIG_W    = MANT_W + 1;
    localparam int PROD_W   = 2 * SIG_W;
    localparam int E_W      = FP_E_W;
    localparam logic signed [E_W-1:0] EXP_ONE = E_W'(1);

    state_t state;
    state_t state_next;

    logic                  accept;
    logic                  in_zero;
    logic [FP_WIDTH-1:0]   op_a_q;
    logic [FP_WIDTH-1:0]   op_b_q;
    logic                  sign_q;
    logic signed [E_W-1:0] exp_q;
    logic [PROD_W-1:0]     mcand_q;
    logic [SIG_W-1:0]      mplr_q;
    logic [PROD_W-1:0]     prod_q;
    logic [1:0]            mult_cnt;
    logic [MANT_W-1:0]     keep_q;
    logic                  guard_q;
    logic                  sticky_q;
    logic [FP_WIDTH-1:0]   result_q;
    logic                  invalid_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic [FP_WIDTH-1:0]   rp_result;
    logic                  rp_overflow;
    logic                  rp_underflow;

    assign accept  = bus.in_valid && (state == IDLE);
    assign in_zero = (bus.op_a[FP_WIDTH-2:MANT_W] == '0) || (bus.op_b[FP_WIDTH-2:MANT_W] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Exceptions and zero operands skip the arithmetic and go straight to DONE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (bus.op_is_exception || in_zero) ? DONE : UNPACK;
                end
            end
            UNPACK: state_next = MULT;
            MULT: begin
                if (mult_cnt == 2'd3) begin
                    state_next = NORM;
                end
            end
            NORM: state_next = PACK;
            PACK: state_next = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            prod_q      <= '0;
            mult_cnt    <= '0;
            keep_q      <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            result_q    <= '0;
            invalid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_a_q      <= bus.op_a;
                        op_b_q      <= bus.op_b;
                        invalid_q   <= 1'b0;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        if (bus.op_is_exception) begin
                            result_q  <= NAN;
                            invalid_q <= 1'b1;
                        end else if (in_zero) begin
                            result_q <= {bus.op_a[FP_WIDTH-1] ^ bus.op_b[FP_WIDTH-1],
                                         {(FP_WIDTH-1){1'b0}}};
                        end
                    end
                end
                UNPACK: begin
                    sign_q   <= op_a_q[FP_WIDTH-1] ^ op_b_q[FP_WIDTH-1];
                    exp_q    <= E_W'(op_a_q[FP_WIDTH-2:MANT_W]) + E_W'(op_b_q[FP_WIDTH-2:MANT_W])
                                - E_W'(BIAS);
                    mcand_q  <= PROD_W'({1'b1, op_a_q[MANT_W-1:0]});
                    mplr_q   <= {1'b1, op_b_q[MANT_W-1:0]};
                    prod_q   <= '0;
                    mult_cnt <= '0;
                end
                MULT: begin
                    if (mplr_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplr_q   <= mplr_q >> 1;
                    mult_cnt <= mult_cnt + 2'd1;
                end
                NORM: begin
                    // Product of two [1,2) significands lies in [1,4); a set MSB means >= 2.
                    if (prod_q[PROD_W-1]) begin
                        exp_q    <= exp_q + EXP_ONE;
                        keep_q   <= prod_q[PROD_W-2 -: MANT_W];
                        guard_q  <= prod_q[MANT_W];
                        sticky_q <= |prod_q[MANT_W-1:0];
                    end else begin
                        keep_q   <= prod_q[PROD_W-3 -: MANT_W];
                        guard_q  <= prod_q[MANT_W-1];
                        sticky_q <= |prod_q[MANT_W-2:0];
                    end
                end
                PACK: begin
                    result_q    <= rp_result;
                    overflow_q  <= rp_overflow;
                    underflow_q <= rp_underflow;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    fp8_round_pack #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W),
        .E_W    (E_W)
    ) u_round_pack (
        .sign      (sign_q),
        .exp_in    (exp_q),
        .keep      (keep_q),
        .guard     (guard_q),
        .sticky    (sticky_q),
        .result    (rp_result),
        .overflow  (rp_overflow),
        .underflow (rp_underflow)
    );

    assign bus.in_ready       = (state == IDLE);
    assign bus.out_valid      = (state == DONE);
    assign bus.result         = result_q;
    assign bus.flag_invalid   = invalid_q;
    assign bus.flag_overflow  = overflow_q;
    assign bus.flag_underflow = underflow_q;

endmodule

// File: tb/tb_fp8_seq_multiplier.sv
// Directed bench for fp8_seq_multiplier with hand-computed expected products.
module tb_fp8_seq_multiplier;
    import fp8_seq_multiplier_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] prev_result = 8'h00;

    fp8_seq_multiplier_if bus();

    fp8_seq_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] flagsNow();
        return {5'b0, bus.flag_invalid, bus.flag_overflow, bus.flag_underflow};
    endfunction

    // Presents one operand pair, then counts edges after the accept edge until out_valid.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic exc,
                                 output int latency, output logic [7:0] res_acc,
                                 output logic [7:0] flags_acc);
        bus.op_a            = a;
        bus.op_b            = b;
        bus.op_is_exception = exc;
        bus.in_valid        = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid        = 1'b0;
        bus.op_a            = 8'hAA;
        bus.op_b            = 8'h55;
        bus.op_is_exception = 1'b0;
        res_acc             = bus.result;
        flags_acc           = flagsNow();
        latency             = 0;
        while (!bus.out_valid && latency < 20) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic runCase(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic exc, input logic [7:0] exp_res, input int exp_lat,
                           input logic [2:0] exp_flags);
        int         lat;
        logic [7:0] res_acc;
        logic [7:0] flags_acc;
        applyStimulus(a, b, exc, lat, res_acc, flags_acc);
        checkOutput({tag, ".latency"}, 8'(lat), 8'(exp_lat));
        checkOutput({tag, ".result"}, bus.result, exp_res);
        checkOutput({tag, ".flags"}, flagsNow(), {5'b0, exp_flags});
        if (exp_lat != 0) begin
            checkOutput({tag, ".held_result"}, res_acc, prev_result);
            checkOutput({tag, ".flags_cleared"}, flags_acc, 8'h00);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, ".in_ready_after"}, {7'b0, bus.in_ready}, 8'h01);
        checkOutput({tag, ".out_valid_after"}, {7'b0, bus.out_valid}, 8'h00);
        prev_result = exp_res;
    endtask

    initial begin
        int         lat;
        logic [7:0] res_acc;
        logic [7:0] flags_acc;

        bus.in_valid        = 1'b0;
        bus.op_a            = 8'h00;
        bus.op_b            = 8'h00;
        bus.op_is_exception = 1'b0;
        bus.out_ready       = 1'b0;
        rst                 = 1'b1;
        #12;
        checkOutput("reset.in_ready", {7'b0, bus.in_ready}, 8'h01);
        checkOutput("reset.out_valid", {7'b0, bus.out_valid}, 8'h00);
        checkOutput("reset.result", bus.result, 8'h00);
        checkOutput("reset.flags", flagsNow(), 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // out_ready while idle must not disturb anything
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("idle_ready.in_ready", {7'b0, bus.in_ready}, 8'h01);
        checkOutput("idle_ready.out_valid", {7'b0, bus.out_valid}, 8'h00);

        runCase("mul_1p5_sq",   8'h3C, 8'h3C, 1'b0, 8'h41, 7, 3'b000);
        runCase("one_sq",       8'h38, 8'h38, 1'b0, 8'h38, 7, 3'b000);
        runCase("rnd_down",     8'h39, 8'h39, 1'b0, 8'h3A, 7, 3'b000);
        runCase("rnd_tie_even", 8'h39, 8'h3C, 1'b0, 8'h3E, 7, 3'b000);
        runCase("rnd_carry",    8'h39, 8'h3E, 1'b0, 8'h40, 7, 3'b000);
        runCase("max_sig",      8'h3F, 8'h3F, 1'b0, 8'h46, 7, 3'b000);
        runCase("neg_mix",      8'hBC, 8'h3C, 1'b0, 8'hC1, 7, 3'b000);
        runCase("ovf",          8'h77, 8'h40, 1'b0, 8'h78, 7, 3'b010);
        runCase("e14_ok",       8'h70, 8'h38, 1'b0, 8'h70, 7, 3'b000);
        runCase("neg_ovf",      8'hF7, 8'h40, 1'b0, 8'hF8, 7, 3'b010);
        runCase("unf",          8'h08, 8'h08, 1'b0, 8'h00, 7, 3'b001);
        runCase("e1_ok",        8'h18, 8'h28, 1'b0, 8'h08, 7, 3'b000);
        runCase("unf_e0",       8'h18, 8'h20, 1'b0, 8'h00, 7, 3'b001);
        runCase("neg_unf",      8'h88, 8'h08, 1'b0, 8'h80, 7, 3'b001);
        runCase("exc",          8'h78, 8'h38, 1'b1, 8'h7F, 0, 3'b100);
        runCase("exc_zero",     8'h00, 8'h38, 1'b1, 8'h7F, 0, 3'b100);
        runCase("zero_a",       8'h00, 8'hC0, 1'b0, 8'h80, 0, 3'b000);
        runCase("zero_b",       8'hC4, 8'h80, 1'b0, 8'h00, 0, 3'b000);

        // Backpressure: result must hold while a stray operand pulse is ignored
        applyStimulus(8'h3C, 8'h3C, 1'b0, lat, res_acc, flags_acc);
        checkOutput("bp.latency", 8'(lat), 8'd7);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.op_a     = 8'h08;
                bus.op_b     = 8'h08;
                bus.in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            checkOutput("bp.result", bus.result, 8'h41);
            checkOutput("bp.in_ready", {7'b0, bus.in_ready}, 8'h00);
            checkOutput("bp.out_valid", {7'b0, bus.out_valid}, 8'h01);
            checkOutput("bp.flags", flagsNow(), 8'h00);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("bp.release_in_ready", {7'b0, bus.in_ready}, 8'h01);
        checkOutput("bp.release_out_valid", {7'b0, bus.out_valid}, 8'h00);
        prev_result = 8'h41;
        runCase("bp_next", 8'h38, 8'h38, 1'b0, 8'h38, 7, 3'b000);

        // Reset during the third multiply cycle aborts the operation
        bus.op_a     = 8'h3C;
        bus.op_b     = 8'h3C;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid.in_ready", {7'b0, bus.in_ready}, 8'h01);
        checkOutput("rst_mid.out_valid", {7'b0, bus.out_valid}, 8'h00);
        checkOutput("rst_mid.result", bus.result, 8'h00);
        checkOutput("rst_mid.flags", flagsNow(), 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_result = 8'h00;
        runCase("after_rst", 8'h3C, 8'h3C, 1'b0, 8'h41, 7, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
